// File: rtl/afifo_pkg.sv
// Shared definitions for the async FIFO: default geometry and gray-code helpers.
// The helpers work on a 32-bit container. Callers zero-extend narrower pointers
// into it and cast the result back to their own width. Zero upper bits do not
// change the code of the lower bits in either direction.
package afifo_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned PTR_WIDTH      = DEF_ADDR_WIDTH + 1;
  localparam int unsigned CODE_WIDTH     = 32;

  // Binary to reflected gray code.
  function automatic logic [CODE_WIDTH-1:0] bin2gray(input logic [CODE_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Reflected gray code to binary, using a running XOR from the MSB down.
  function automatic logic [CODE_WIDTH-1:0] gray2bin(input logic [CODE_WIDTH-1:0] gray);
    logic [CODE_WIDTH-1:0] bin;
    bin = '0;
    bin[CODE_WIDTH-1] = gray[CODE_WIDTH-1];
    for (int i = int'(CODE_WIDTH) - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/afifo_rd_ctrl_sync.sv
// Three-flop synchronizer for a gray-coded bus that enters from another clock domain.
// Ports:
//   clk    destination-domain clock
//   reset  synchronous, active-high; loads RESET_STATE into all stages
//   d      asynchronous input bus
//   q      synchronized output, three edges after d
module afifo_rd_ctrl_sync #(
  parameter int unsigned             WIDTH       = 5,
  parameter logic [WIDTH-1:0]        RESET_STATE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] stage;

  // Only one bit of a gray bus changes per update, so per-bit resolution is safe.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta  <= RESET_STATE;
      stage <= RESET_STATE;
      q     <= RESET_STATE;
    end else begin
      meta  <= d;
      stage <= meta;
      q     <= stage;
    end
  end

endmodule

// File: rtl/afifo_rd_ctrl.sv
// Read-side controller of the async FIFO, in the read clock domain.
// It owns the read pointer and the empty flag and issues RAM reads. It brings the
// write pointer across through a synchronizer. It presents the head entry as a
// first-word-fall-through valid/ready stream through a 2-entry skid buffer.
// Ports:
//   clk, reset     read clock; synchronous active-high reset
//   wptr_gray_i    write pointer (gray) from the write domain, unsynchronized
//   mem_ren_o      RAM read enable (combinational)
//   mem_raddr_o    RAM read address
//   mem_rdata_i    RAM read data, valid one cycle after mem_ren_o
//   rptr_gray_o    registered gray read pointer, to the write domain
//   rd_valid_o     head entry valid
//   rd_ready_i     consumer accepts the head entry
//   rd_data_o      head entry
//   empty_o        registered; no unread entries left in RAM
//   level_o        synchronized write pointer minus read pointer
module afifo_rd_ctrl
  import afifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH:0]   wptr_gray_i,
  output logic                  mem_ren_o,
  output logic [ADDR_WIDTH-1:0] mem_raddr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [ADDR_WIDTH:0]   rptr_gray_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  empty_o,
  output logic [ADDR_WIDTH:0]   level_o
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic [PW-1:0]         wq;
  logic [PW-1:0]         rptr_bin;
  logic [PW-1:0]         rptr_next;
  logic [PW-1:0]         rptr_gray_next;
  logic                  pend;
  logic [1:0]            count;
  logic [2:0]            occ;
  logic                  pop;
  logic                  rd_idx;
  logic                  wr_idx;
  logic [DATA_WIDTH-1:0] skid [2];

  afifo_rd_ctrl_sync #(
    .WIDTH       (PW),
    .RESET_STATE ('0)
  ) u_wptr_sync (
    .clk   (clk),
    .reset (reset),
    .d     (wptr_gray_i),
    .q     (wq)
  );

  // Reads are issued only while the skid buffer has room for the data in flight.
  always_comb begin
    pop            = rd_valid_o & rd_ready_i;
    occ            = 3'(count) + 3'(pend) - 3'(pop);
    mem_ren_o      = !empty_o && (occ < 3'd2);
    rptr_next      = rptr_bin + PW'(mem_ren_o);
    rptr_gray_next = PW'(bin2gray(CODE_WIDTH'(rptr_next)));
    mem_raddr_o    = rptr_bin[ADDR_WIDTH-1:0];
    level_o        = PW'(gray2bin(CODE_WIDTH'(wq))) - rptr_bin;
    rd_valid_o     = (count != 2'd0);
    rd_data_o      = skid[rd_idx];
  end

  // Pointer, empty flag, in-flight flag and skid buffer state.
  always_ff @(posedge clk) begin
    if (reset) begin
      rptr_bin    <= '0;
      rptr_gray_o <= '0;
      empty_o     <= 1'b1;
      pend        <= 1'b0;
      count       <= 2'd0;
      rd_idx      <= 1'b0;
      wr_idx      <= 1'b0;
      skid        <= '{default: '0};
    end else begin
      rptr_bin    <= rptr_next;
      rptr_gray_o <= rptr_gray_next;
      // Compare against the synchronized (possibly stale) pointer so empty stays pessimistic.
      empty_o     <= (rptr_gray_next == wq);
      pend        <= mem_ren_o;
      if (pend) begin
        skid[wr_idx] <= mem_rdata_i;
        wr_idx       <= ~wr_idx;
      end
      if (pop) begin
        rd_idx <= ~rd_idx;
      end
      count <= count + 2'(pend) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_afifo_rd_ctrl.sv
// Bench for the async FIFO read controller. A behavioural writer fills a RAM
// model and a queue of expected entries. A negedge monitor pops that queue on
// every accepted transfer. Directed phases cover reset, latency, full FIFO,
// random backpressure, mid-operation reset and streaming.
module tb_afifo_rd_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned PW = AW + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] wptr_gray_i;
  logic          mem_ren_o;
  logic [AW-1:0] mem_raddr_o;
  logic [DW-1:0] mem_rdata_i;
  logic [PW-1:0] rptr_gray_o;
  logic          rd_valid_o;
  logic          rd_ready_i;
  logic [DW-1:0] rd_data_o;
  logic          empty_o;
  logic [PW-1:0] level_o;

  afifo_rd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .wptr_gray_i (wptr_gray_i),
    .mem_ren_o   (mem_ren_o),
    .mem_raddr_o (mem_raddr_o),
    .mem_rdata_i (mem_rdata_i),
    .rptr_gray_o (rptr_gray_o),
    .rd_valid_o  (rd_valid_o),
    .rd_ready_i  (rd_ready_i),
    .rd_data_o   (rd_data_o),
    .empty_o     (empty_o),
    .level_o     (level_o)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned passed = 0;

  logic [DW-1:0] ram [2**AW];
  logic [DW-1:0] exp_q [$];
  logic [PW-1:0] wbin;

  function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] from_gray(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = '0;
    for (int i = int'(PW) - 1; i >= 0; i--) begin
      b[i] = g[i] ^ ((i == int'(PW) - 1) ? 1'b0 : b[i+1]);
    end
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Synchronous RAM model: data appears one edge after the read enable.
  always @(posedge clk) begin
    if (mem_ren_o) mem_rdata_i <= ram[mem_raddr_o];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [DW-1:0] d);
    ram[wbin[AW-1:0]] = d;
    exp_q.push_back(d);
    wbin = wbin + 1'b1;
    wptr_gray_i = to_gray(wbin);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rd_ready_i = 1'b0;
    wbin = '0;
    wptr_gray_i = '0;
    exp_q.delete();
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  // Scoreboard monitor and the read-while-empty invariant.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check("ren_while_empty", 32'(mem_ren_o & empty_o), 32'd0);
      if (rd_valid_o && rd_ready_i) begin
        if (exp_q.size() == 0) check("pop_unexpected", 32'(rd_data_o), 32'hFFFF_FFFF);
        else check("pop_data", 32'(rd_data_o), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    int written;
    int cyc;
    logic [DW-1:0] held;

    reset = 1'b1;
    rd_ready_i = 1'b0;
    wbin = '0;
    wptr_gray_i = '0;
    mem_rdata_i = '0;
    for (int i = 0; i < 2**AW; i++) ram[i] = '0;

    // Phase 1: reset state held for 10 clocks.
    #1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (mem_ren_o !== 1'b0) bad++;
    end
    check("rst_ren_never", 32'(bad), 32'd0);
    check("rst_empty", 32'(empty_o), 32'd1);
    check("rst_valid", 32'(rd_valid_o), 32'd0);
    check("rst_rptr", 32'(rptr_gray_o), 32'd0);
    check("rst_level", 32'(level_o), 32'd0);
    check("rst_data", 32'(rd_data_o), 32'd0);
    reset = 1'b0;
    step();
    step();

    // Phase 2: one entry, latency and hold under backpressure.
    write_entry(8'hA5);
    for (int i = 0; i < 5; i++) step();
    check("lat_not_before_6", 32'(rd_valid_o), 32'd0);
    step();
    check("lat_valid_at_6", 32'(rd_valid_o), 32'd1);
    check("lat_data", 32'(rd_data_o), 32'hA5);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (rd_valid_o !== 1'b1 || rd_data_o !== 8'hA5) bad++;
    end
    check("hold_stable", 32'(bad), 32'd0);
    rd_ready_i = 1'b1;
    step();
    rd_ready_i = 1'b0;
    check("single_pop_valid", 32'(rd_valid_o), 32'd0);
    check("single_pop_rptr", 32'(rptr_gray_o), 32'd1);
    check("single_pop_level", 32'(level_o), 32'd0);

    // Phase 3: full FIFO, back-to-back pops and pointer MSB wrap.
    do_reset();
    for (int i = 0; i < 16; i++) write_entry(8'($urandom));
    rd_ready_i = 1'b1;
    step(); step(); step();
    check("full_level", 32'(level_o), 32'd16);
    check("full_empty_lag", 32'(empty_o), 32'd1);
    step();
    check("full_not_empty", 32'(empty_o), 32'd0);
    step(); step();
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (rd_valid_o !== 1'b1) bad++;
      step();
    end
    check("full_b2b_gaps", 32'(bad), 32'd0);
    check("full_drained_valid", 32'(rd_valid_o), 32'd0);
    check("full_drained_empty", 32'(empty_o), 32'd1);
    check("full_rptr_wrap", 32'(rptr_gray_o), 32'(to_gray(5'd16)));
    check("full_drained_level", 32'(level_o), 32'd0);
    check("full_queue_drained", 32'(exp_q.size()), 32'd0);
    rd_ready_i = 1'b0;

    // Phase 4: random writes and random backpressure over 100 entries.
    do_reset();
    written = 0;
    cyc = 0;
    while ((written < 100 || exp_q.size() != 0) && cyc < 4000) begin
      rd_ready_i = ($urandom_range(0, 3) != 0);
      if (written < 100 && $urandom_range(0, 1) == 1 &&
          (wbin - from_gray(rptr_gray_o)) < PW'(16)) begin
        write_entry(8'($urandom));
        written++;
      end
      step();
      cyc++;
    end
    check("rand_all_written", 32'(written), 32'd100);
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    rd_ready_i = 1'b0;
    step(); step();
    check("rand_final_empty", 32'(empty_o), 32'd1);
    check("rand_final_rptr", 32'(rptr_gray_o), 32'(to_gray(7'd100 % 7'd32)));

    // Phase 5: reset while a read is in flight and the skid buffer is loaded.
    do_reset();
    for (int i = 0; i < 4; i++) write_entry(8'h10 + 8'(i));
    for (int i = 0; i < 6; i++) step();
    check("midrst_loaded", 32'(rd_valid_o), 32'd1);
    held = rd_data_o;
    check("midrst_head", 32'(held), 32'h10);
    reset = 1'b1;
    wbin = '0;
    wptr_gray_i = '0;
    exp_q.delete();
    step();
    check("midrst_valid", 32'(rd_valid_o), 32'd0);
    check("midrst_ren", 32'(mem_ren_o), 32'd0);
    check("midrst_rptr", 32'(rptr_gray_o), 32'd0);
    check("midrst_empty", 32'(empty_o), 32'd1);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rd_valid_o !== 1'b0 || mem_ren_o !== 1'b0) bad++;
    end
    check("midrst_no_stale", 32'(bad), 32'd0);

    // Phase 6: one write per clock with the consumer always ready.
    do_reset();
    rd_ready_i = 1'b1;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      if (c >= 6 && c < 46 && rd_valid_o !== 1'b1) bad++;
      if (c < 40) write_entry(8'($urandom));
      step();
    end
    check("stream_continuous", 32'(bad), 32'd0);
    check("stream_end_valid", 32'(rd_valid_o), 32'd0);
    check("stream_drained", 32'(exp_q.size()), 32'd0);
    rd_ready_i = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
